// File: rtl/iob_regfile_mp_be_pkg.sv
// iob_regfile_mp_be_pkg: clear engine state encodings shared by the register file slice.
package iob_regfile_mp_be_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
endpackage

// File: rtl/iob_regfile_clr_fsm.sv
// iob_regfile_clr_fsm: walks every entry once on clr_req, driving the clear write address and enable.
module iob_regfile_clr_fsm
  import iob_regfile_mp_be_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  logic [0:0] state;
  logic [ADDR_W-1:0] cnt;
  assign clr_busy = state == CLEAR;
  assign clr_we = clr_busy;
  assign clr_addr = cnt;
  // The counter wraps to zero on the last entry, so no terminal state is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == IDLE) begin
      state <= clr_req ? CLEAR : IDLE;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= IDLE;
    end
  end
endmodule

// File: rtl/iob_regfile_mp_be.sv
// iob_regfile_mp_be: byte-strobed register file with N_RD registered read ports and a sequential clear engine.
// Define IOB_REGFILE_BYPASS_EN for write-first forwarding on the read ports.
module iob_regfile_mp_be
  import iob_regfile_mp_be_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int N_RD = 2,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   w_ready,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      w_addr,
  input  logic [DATA_W/8-1:0]    w_strb,
  input  logic [DATA_W-1:0]      w_data,
  input  logic [N_RD*ADDR_W-1:0] r_addr,
  output logic [N_RD*DATA_W-1:0] r_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic wr;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] d,
                                               input logic [DATA_W/8-1:0] s);
    logic [DATA_W-1:0] r;
    r = old;
    for (int k = 0; k < DATA_W / 8; k++) if (s[k]) r[8*k+:8] = d[8*k+:8];
    return r;
  endfunction
  iob_regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk(clk),
    .rst(rst),
    .clr_req(clr_req),
    .clr_busy(clr_busy),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  assign w_ready = !clr_busy;
  assign wr = we && w_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) mem[w_addr] <= merge(mem[w_addr], w_data, w_strb);
      if (clr_we) mem[clr_addr] <= CLR_VAL;
    end
  end
  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] q;
    assign ra = r_addr[p*ADDR_W+:ADDR_W];
`ifdef IOB_REGFILE_BYPASS_EN
    always_comb nxt = (clr_we && ra == clr_addr) ? CLR_VAL :
                      (wr && ra == w_addr) ? merge(mem[ra], w_data, w_strb) : mem[ra];
`else
    always_comb nxt = mem[ra];
`endif
    always_ff @(posedge clk) q <= rst ? '0 : nxt;
    assign r_data[p*DATA_W+:DATA_W] = q;
  end
endmodule
